// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and latency helpers for ALU issue control.
package alu_pkg;

  localparam logic [5:0] OpNop  = 6'b000000;
  localparam logic [5:0] OpAdd  = 6'b001000;
  localparam logic [5:0] OpSub  = 6'b001100;
  localparam logic [5:0] OpMul  = 6'b100110;
  localparam logic [5:0] OpMulu = 6'b100111;
  localparam logic [5:0] OpDiv  = 6'b000100;
  localparam logic [5:0] OpDivu = 6'b000101;
  localparam logic [5:0] OpMod  = 6'b000110;
  localparam logic [5:0] OpModu = 6'b000111;

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  function automatic logic is_div(input logic [5:0] op);
    return (op == OpDiv) || (op == OpDivu) || (op == OpMod) || (op == OpModu);
  endfunction

  function automatic logic [CntW-1:0] op_latency(input logic [5:0]  op,
                                                 input int unsigned mul_cycles,
                                                 input int unsigned div_cycles);
    if ((op == OpMul) || (op == OpMulu)) return CntW'(mul_cycles);
    if (is_div(op)) return CntW'(div_cycles);
    return CntW'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-master round-robin arbiter: combinational grant, pointer advances on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // High when requester 1 has priority on a tie.
  logic prio_q;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = prio_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (accept_i && (gnt_o != 2'b00)) begin
      prio_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational ALU between two requesters, holding operands for the
// opcode latency and returning results/faults through a valid/ready response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_d0,
  output logic [31:0] alu_d1,
  output logic [5:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_error,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        err_irq,
  output logic        busy
);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       alu_d0_q, alu_d1_q, resp_data_q;
  logic [5:0]        alu_op_q;
  logic              resp_valid_q, resp_id_q, resp_err_q, err_irq_q, dz_q;

  logic [1:0]        gnt;
  logic              accept, sel, fault;
  logic [5:0]        sel_op;
  logic [31:0]       sel_a, sel_b;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({req1_valid, req0_valid}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign accept     = (state_q == StIdle) && (gnt != 2'b00);
  assign req0_ready = (state_q == StIdle) && gnt[0];
  assign req1_ready = (state_q == StIdle) && gnt[1];
  assign sel        = gnt[1];
  assign sel_op     = sel ? req1_op : req0_op;
  assign sel_a      = sel ? req1_a  : req0_a;
  assign sel_b      = sel ? req1_b  : req0_b;
  // Divide-by-zero never reaches the ALU, so its flag is synthesised here.
  assign fault      = dz_q || alu_error;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_d0_q     <= '0;
      alu_d1_q     <= '0;
      alu_op_q     <= OpNop;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      err_irq_q    <= 1'b0;
      dz_q         <= 1'b0;
    end else begin
      err_irq_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            resp_id_q <= sel;
            alu_d0_q  <= sel_a;
            alu_d1_q  <= sel_b;
            if (is_div(sel_op) && (sel_b == 32'd0)) begin
              alu_op_q <= OpNop;
              dz_q     <= 1'b1;
              cnt_q    <= '0;
            end else begin
              alu_op_q <= sel_op;
              dz_q     <= 1'b0;
              cnt_q    <= op_latency(sel_op, MUL_CYCLES, DIV_CYCLES) - CntW'(1);
            end
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= fault;
            resp_data_q  <= fault ? 32'd0 : alu_out;
            err_irq_q    <= fault;
            alu_op_q     <= OpNop;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_d0     = alu_d0_q;
  assign alu_d1     = alu_d1_q;
  assign alu_op     = alu_op_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign err_irq    = err_irq_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU model.
module tb_alu_issue_ctrl;

  localparam logic [5:0] ADD  = 6'b001000;
  localparam logic [5:0] ADDU = 6'b001001;
  localparam logic [5:0] SUB  = 6'b001100;
  localparam logic [5:0] SUBU = 6'b001101;
  localparam logic [5:0] DIV  = 6'b000100;
  localparam logic [5:0] DIVU = 6'b000101;
  localparam logic [5:0] MODU = 6'b000111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [31:0] alu_d0, alu_d1, alu_out, resp_data;
  logic [5:0]  alu_op;
  logic        alu_error;
  logic        resp_valid, resp_ready = 1'b0, resp_id, resp_err, err_irq, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_d0     (alu_d0),
    .alu_d1     (alu_d1),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .alu_error  (alu_error),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .err_irq    (err_irq),
    .busy       (busy)
  );

  // External ALU model; unknown opcodes (including NOP) yield 0.
  always_comb begin
    alu_out   = 32'd0;
    alu_error = 1'b0;
    case (alu_op)
      ADD: begin
        alu_out   = alu_d0 + alu_d1;
        alu_error = (alu_d0[31] == alu_d1[31]) && (alu_out[31] != alu_d0[31]);
      end
      ADDU: alu_out = alu_d0 + alu_d1;
      SUB: begin
        alu_out   = alu_d0 - alu_d1;
        alu_error = (alu_d0[31] != alu_d1[31]) && (alu_out[31] != alu_d0[31]);
      end
      SUBU: alu_out = alu_d0 - alu_d1;
      DIV:  if (alu_d1 != 0) alu_out = $signed(alu_d0) / $signed(alu_d1);
      DIVU: if (alu_d1 != 0) alu_out = alu_d0 / alu_d1;
      MODU: if (alu_d1 != 0) alu_out = alu_d0 % alu_d1;
      default: alu_out = 32'd0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    apply_reset();
    n_tests++;
    if ({resp_valid, resp_id, resp_err, err_irq, busy, req0_ready, req1_ready} !== 7'b0 ||
        alu_op !== 6'd0 || alu_d0 !== 32'd0 || alu_d1 !== 32'd0 || resp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: op=%h d0=%h d1=%h rv=%b data=%h busy=%b, required all zero",
               alu_op, alu_d0, alu_d1, resp_valid, resp_data, busy);
    end
  endtask

  task automatic test_add;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL add_ready: got %b required 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if (alu_op !== ADD || alu_d0 !== 32'd5 || alu_d1 !== 32'd7 || resp_valid !== 1'b0 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_issue: op=%h d0=%0d d1=%0d rv=%b busy=%b required 08/5/7/0/1",
               alu_op, alu_d0, alu_d1, resp_valid, busy);
    end
    tick();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'd12 || resp_err !== 1'b0 ||
        err_irq !== 1'b0 || alu_op !== 6'd0) begin
      n_fail++;
      $display("FAIL add_resp: rv=%b id=%b data=%0d err=%b irq=%b op=%h required 1/0/12/0/0/00",
               resp_valid, resp_id, resp_data, resp_err, err_irq, alu_op);
    end
    tick();
    n_tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL add_done: rv=%b busy=%b required 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_data;
    apply_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = ADDU; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = SUBU; req1_a = 32'd9; req1_b = 32'd4;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_data = (i % 2 == 0) ? 32'd2 : 32'd5;
      n_tests++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: ready{1,0}=%b required %b", i, {req1_ready, req0_ready},
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
      tick();
      n_tests++;
      if (resp_valid !== 1'b1 || resp_id !== 1'(i % 2) || resp_data !== exp_data) begin
        n_fail++;
        $display("FAIL rr_resp%0d: rv=%b id=%b data=%0d required 1/%0d/%0d",
                 i, resp_valid, resp_id, resp_data, i % 2, exp_data);
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_div;
    resp_ready = 1'b1;
    req1_valid = 1'b1; req1_op = DIV; req1_a = 32'd100; req1_b = 32'd7;
    #1;
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_fail++; $display("FAIL div_ready: got %b required 10", {req1_ready, req0_ready});
    end
    tick();
    req1_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n_tests++;
      if (alu_op !== DIV || alu_d0 !== 32'd100 || alu_d1 !== 32'd7 || resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL div_hold%0d: op=%h d0=%0d d1=%0d rv=%b required 04/100/7/0",
                 k, alu_op, alu_d0, alu_d1, resp_valid);
      end
      tick();
    end
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== 32'd14 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL div_resp: rv=%b id=%b data=%0d err=%b required 1/1/14/0",
               resp_valid, resp_id, resp_data, resp_err);
    end
    tick();
  endtask

  task automatic test_overflow;
    int irq_count;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1;
    tick();
    req0_valid = 1'b0;
    tick();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'd0 || err_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_resp: rv=%b err=%b data=%h irq=%b required 1/1/0/1",
               resp_valid, resp_err, resp_data, err_irq);
    end
    irq_count = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (err_irq) irq_count++;
      n_tests++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'd0 || resp_id !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_stall%0d: rv=%b err=%b data=%h id=%b required 1/1/0/0",
                 k, resp_valid, resp_err, resp_data, resp_id);
      end
    end
    n_tests++;
    if (irq_count !== 0) begin
      n_fail++; $display("FAIL ovf_irq_repulse: extra pulses=%0d required 0", irq_count);
    end
    resp_ready = 1'b1;
    tick();
    n_tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ovf_release: rv=%b busy=%b required 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_divzero;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = MODU; req0_a = 32'd10; req0_b = 32'd0;
    tick();
    req0_valid = 1'b0;
    n_tests++;
    if (alu_op !== 6'd0 || err_irq !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_issue: op=%h irq=%b busy=%b required 00/0/1", alu_op, err_irq, busy);
    end
    tick();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'd0 || err_irq !== 1'b1 ||
        alu_op !== 6'd0) begin
      n_fail++;
      $display("FAIL dz_resp: rv=%b err=%b data=%h irq=%b op=%h required 1/1/0/1/00",
               resp_valid, resp_err, resp_data, err_irq, alu_op);
    end
    tick();
    n_tests++;
    if (err_irq !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL dz_after: irq=%b rv=%b required 0/0", err_irq, resp_valid);
    end
  endtask

  task automatic test_unknown_op;
    resp_ready = 1'b1;
    req1_valid = 1'b1; req1_op = 6'b111111; req1_a = 32'd3; req1_b = 32'd4;
    tick();
    req1_valid = 1'b0;
    tick();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'd0 || err_irq !== 1'b0 ||
        resp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL unknown_op: rv=%b err=%b data=%h irq=%b id=%b required 1/0/0/0/1",
               resp_valid, resp_err, resp_data, err_irq, resp_id);
    end
    tick();
  endtask

  task automatic test_reset_mid_op;
    int stale;
    resp_ready = 1'b1;
    req1_valid = 1'b1; req1_op = DIV; req1_a = 32'd100; req1_b = 32'd7;
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({resp_valid, resp_id, resp_err, err_irq, busy} !== 5'b0 || alu_op !== 6'd0 ||
        alu_d0 !== 32'd0 || alu_d1 !== 32'd0 || resp_data !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: op=%h d0=%h d1=%h rv=%b busy=%b required all zero",
               alu_op, alu_d0, alu_d1, resp_valid, busy);
    end
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (resp_valid || err_irq || busy) stale++;
    end
    n_tests++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL midrst_stale: active cycles=%0d required 0", stale);
    end
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd3; req0_b = 32'd4;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready: got %b required 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    n_tests++;
    if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'd7 || resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_next: rv=%b id=%b data=%0d err=%b required 1/0/7/0",
               resp_valid, resp_id, resp_data, resp_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_div();
    test_overflow();
    test_divzero();
    test_unknown_op();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Shares the single combinational ALU between two requesters (req0 = integer pipeline EX stage, req1 = auxiliary/address unit).
- Round-robin arbitration, one operation in flight at a time.
- Holds ALU operands stable for an opcode-dependent number of cycles, so slow MUL/DIV/MOD paths can be multicycle-constrained.
- Returns the result with a valid/ready handshake and converts ALU overflow and divide-by-zero into an error response plus an interrupt pulse.

Parameters:
- MUL_CYCLES, 2, cycles ALU inputs are held for MUL/MULU (>=1).
- DIV_CYCLES, 8, cycles held for DIV/DIVU/MOD/MODU (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  6  requester 0 ALU opcode.
- req0_a  in  32  requester 0 operand D0.
- req0_b  in  32  requester 0 operand D1.
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same as req0, requester 1.
- alu_d0  out  32  registered ALU D0.
- alu_d1  out  32  registered ALU D1.
- alu_op  out  6  registered ALU OpCode.
- alu_out  in  32  ALU result.
- alu_error  in  1  ALU overflow flag (ADD/SUB).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester index of response.
- resp_data  out  32  result; 0 when resp_err=1.
- resp_err  out  1  operation faulted.
- err_irq  out  1  one-cycle pulse to interrupt module on fault.
- busy  out  1  high whenever state != IDLE.

Behaviour:
Reset:
- All outputs 0; alu_op = 6'b000000 (ALU default path, out = 0).
- State IDLE; round-robin pointer favours req0.
- Reset mid-operation drops the in-flight op; no response or irq is produced.

States: IDLE, EXEC, RESP.

IDLE:
- Winner selection: only one valid -> that requester. Both valid -> the requester not granted last.
- reqN_ready is high combinationally for the winner only; all ready signals are low in any other state.
- On the accept edge: latch op/a/b into alu_op/alu_d0/alu_d1, record resp_id, update the RR pointer, and load the counter with latency-1.
- Latency: MUL/MULU = MUL_CYCLES; DIV/DIVU/MOD/MODU = DIV_CYCLES; all other opcodes = 1.
- Divide-by-zero: a div/mod opcode with b==0 is accepted but not issued. alu_op stays 6'b000000, the next state is RESP with resp_err=1, and latency is forced to 1.

EXEC:
- ALU inputs are held constant. The counter decrements each cycle.
- At counter==0: capture alu_out and alu_error. resp_data = alu_error ? 0 : alu_out, resp_err = alu_error.
- Assert resp_valid from the next cycle; alu_op returns to 6'b000000; go to RESP.
- resp_valid rises exactly L cycles after the accept edge.

RESP:
- resp_valid, resp_id, resp_data and resp_err are held stable until resp_valid && resp_ready.
- err_irq pulses for the single cycle in which resp_valid first rises with resp_err=1. It is never re-pulsed while the response stalls.
- On handshake: resp_valid=0, go to IDLE. The next accept occurs no earlier than the following cycle, so peak throughput is one op per L+2 cycles.

Other rules:
- Unknown opcodes are issued with latency 1; the result is the ALU's 0; they are not an error.
- Requests are sampled only in IDLE. A requester may drop valid before it is granted without side effects.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (ADD 6'b001000, SUB 6'b001100, MUL 6'b100110, MULU 6'b100111, DIV 6'b000100, DIVU 6'b000101, MOD 6'b000110, MODU 6'b000111, NOP 6'b000000).
  - State encoding.
  - Functions is_div(op) and op_latency(op, MUL_CYCLES, DIV_CYCLES).
- One sub-module, rr_arbiter2: combinational grant with a registered last-grant pointer and an accept strobe. It is reused by other two-master resources.

Test Plan:
- req0 ADD a=5 b=7, resp_ready=1 -> alu_op=6'b001000 for 1 cycle; resp_valid 1 cycle after accept, resp_id=0, resp_data=12, resp_err=0, no err_irq.
- Both valid from reset, req0 ADDU 1+1 and req1 SUBU 9-4 -> req0 served first (data 2), then req1 (data 5, resp_id=1). Repeat with both still valid -> grants alternate 0,1,0,1.
- req1 DIV a=100 b=7, DIV_CYCLES=8 -> alu_d0/alu_d1/alu_op stable for 8 cycles; resp_valid 8 cycles after accept, data 14.
- req0 ADD 0x7FFFFFFF+1 (alu_error=1) -> resp_err=1, resp_data=0, err_irq high exactly 1 cycle. Hold resp_ready=0 for 5 cycles -> response held, no second irq.
- req0 MODU a=10 b=0 -> alu_op stays 6'b000000, resp_err=1, data 0, err_irq pulse 1 cycle after accept.
- rst_n low in cycle 3 of an 8-cycle DIV -> all outputs 0 immediately; after release, no stale response appears and the next request is served normally.
